// File: rtl/neopix_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : neopix_frame_scheduler
// Brief    : Bank owner and start sequencer for the double-buffered NeoPixel
//            frame store. The SPI writer fills WR_BANK while the ws2812
//            driver reads RD_BANK. Banks swap only while the driver is idle.
//            The block also issues the one-cycle driver start pulse and an
//            optional periodic re-send of the frame on display.
// Options  : NEOPIX_FRAME_STATS_EN adds the FRAMES_SHOWN / FRAMES_DROPPED
//            saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module neopix_frame_scheduler #(
   parameter int NUM_LEDS     = 256,
   parameter int SYSTEM_CLOCK = 50000000,
   parameter int REFRESH_HZ   = 30,
   localparam int CW          = $clog2(NUM_LEDS) + 1
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          WR_DONE,
   input  logic [CW-1:0] WR_COUNT,
   output logic          WR_READY,
   output logic          WR_BANK,
   output logic          RD_BANK,
   input  logic          REFRESH_EN,
   input  logic          DRV_BUSY,
   output logic          DRV_START,
   output logic [CW-1:0] DRV_COUNT
`ifdef NEOPIX_FRAME_STATS_EN
   ,
   output logic [15:0]   FRAMES_SHOWN,
   output logic [15:0]   FRAMES_DROPPED
`endif
);

   // Refresh period in CLK cycles; the timer runs 0 .. period-1 and then holds.
   localparam int c_refresh_period = SYSTEM_CLOCK / REFRESH_HZ;
   localparam int c_tw             = (c_refresh_period > 1) ? $clog2(c_refresh_period) : 1;
   localparam logic [c_tw-1:0] c_timer_max = c_tw'(c_refresh_period - 1);
   localparam logic [CW-1:0]   c_max_count = CW'(NUM_LEDS);
   // Number of cycles the driver gets to raise BUSY after a start pulse.
   localparam logic [2:0]      c_wait_last = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_SENDING   = 2'd3
   } state_t;

   state_t          r_state;
   logic            r_rd_bank;
   logic            r_wr_ready;
   logic            r_drv_start;
   logic [CW-1:0]   r_drv_count;
   logic [CW-1:0]   r_latched;
   logic            r_pending;
   logic            r_shown;
   logic [2:0]      r_wait_cnt;
   logic [c_tw-1:0] r_timer;

   logic [CW-1:0]   w_clamped;
   logic            w_capture;
   logic            w_overrun;
   logic            w_timeout;
   logic            w_timer_expired;
   logic            w_issue_start;

   // Clamp the writer's count to the frame store size and classify WR_DONE.
   always_comb begin
      w_clamped       = (WR_COUNT > c_max_count) ? c_max_count : WR_COUNT;
      w_capture       = WR_DONE &  r_wr_ready;
      w_overrun       = WR_DONE & ~r_wr_ready;
      w_timeout       = (r_state == ST_WAIT_BUSY) && !DRV_BUSY && (r_wait_cnt == c_wait_last);
      w_timer_expired = (r_timer == c_timer_max);
      // The edge that leaves START is the edge that raises DRV_START.
      w_issue_start   = (r_state == ST_START);
   end

   // Frame capture, bank ownership and the driver handshake FSM.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= ST_IDLE;
         r_rd_bank   <= 1'b1;
         r_wr_ready  <= 1'b1;
         r_drv_start <= 1'b0;
         r_drv_count <= '0;
         r_latched   <= '0;
         r_pending   <= 1'b0;
         r_shown     <= 1'b0;
         r_wait_cnt  <= '0;
      end else begin
         r_drv_start <= 1'b0;

         // A pending frame always has WR_READY low, so capture and swap
         // never touch WR_READY on the same edge.
         if (w_capture) begin
            r_latched  <= w_clamped;
            r_pending  <= 1'b1;
            r_wr_ready <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (r_pending && !DRV_BUSY) begin
                  r_rd_bank   <= ~r_rd_bank;
                  r_drv_count <= r_latched;
                  r_pending   <= 1'b0;
                  r_wr_ready  <= 1'b1;
                  r_shown     <= 1'b1;
                  // An empty frame still hands the bank over but is not sent.
                  if (r_latched != '0) begin
                     r_state <= ST_START;
                  end
               end else if (!r_pending && REFRESH_EN && r_shown &&
                            w_timer_expired && !DRV_BUSY) begin
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               r_drv_start <= 1'b1;
               r_wait_cnt  <= '0;
               r_state     <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (DRV_BUSY) begin
                  r_state <= ST_SENDING;
               end else if (r_wait_cnt == c_wait_last) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 3'd1;
               end
            end
            ST_SENDING: begin
               if (!DRV_BUSY) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Refresh timer: frozen while refresh is off, restarted by each start pulse.
   always_ff @(posedge CLK) begin
      if (RESET || !REFRESH_EN) begin
         r_timer <= '0;
      end else if (w_issue_start) begin
         r_timer <= '0;
      end else if (!w_timer_expired) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   assign WR_READY  = r_wr_ready;
   assign RD_BANK   = r_rd_bank;
   assign WR_BANK   = ~r_rd_bank;
   assign DRV_START = r_drv_start;
   assign DRV_COUNT = r_drv_count;

`ifdef NEOPIX_FRAME_STATS_EN
   logic [15:0] r_frames_shown;
   logic [15:0] r_frames_dropped;
   logic [16:0] w_drop_sum;

   // Overrun and timeout can land on the same edge, so add both at once.
   always_comb begin
      w_drop_sum = {1'b0, r_frames_dropped} + {16'd0, w_overrun} + {16'd0, w_timeout};
   end

   // Saturating frame statistics.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_frames_shown   <= '0;
         r_frames_dropped <= '0;
      end else begin
         if (w_issue_start && (r_frames_shown != 16'hFFFF)) begin
            r_frames_shown <= r_frames_shown + 16'd1;
         end
         r_frames_dropped <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
   end

   assign FRAMES_SHOWN   = r_frames_shown;
   assign FRAMES_DROPPED = r_frames_dropped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_neopix_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_neopix_frame_scheduler
// Brief    : Directed self-checking bench for neopix_frame_scheduler with a
//            small driver model that holds BUSY for a set number of cycles
//            after each start pulse. Stats checks compile in when
//            NEOPIX_FRAME_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neopix_frame_scheduler;

   localparam int NUM_LEDS     = 256;
   localparam int SYSTEM_CLOCK = 1000;
   localparam int REFRESH_HZ   = 10;
   localparam int CW           = $clog2(NUM_LEDS) + 1;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          WR_DONE;
   logic [CW-1:0] WR_COUNT;
   logic          WR_READY;
   logic          WR_BANK;
   logic          RD_BANK;
   logic          REFRESH_EN;
   logic          DRV_BUSY;
   logic          DRV_START;
   logic [CW-1:0] DRV_COUNT;
`ifdef NEOPIX_FRAME_STATS_EN
   logic [15:0]   FRAMES_SHOWN;
   logic [15:0]   FRAMES_DROPPED;
`endif

   neopix_frame_scheduler #(
      .NUM_LEDS     (NUM_LEDS),
      .SYSTEM_CLOCK (SYSTEM_CLOCK),
      .REFRESH_HZ   (REFRESH_HZ)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .WR_DONE    (WR_DONE),
      .WR_COUNT   (WR_COUNT),
      .WR_READY   (WR_READY),
      .WR_BANK    (WR_BANK),
      .RD_BANK    (RD_BANK),
      .REFRESH_EN (REFRESH_EN),
      .DRV_BUSY   (DRV_BUSY),
      .DRV_START  (DRV_START),
      .DRV_COUNT  (DRV_COUNT)
`ifdef NEOPIX_FRAME_STATS_EN
      ,
      .FRAMES_SHOWN   (FRAMES_SHOWN),
      .FRAMES_DROPPED (FRAMES_DROPPED)
`endif
   );

   // 10 ns clock.
   always #5 CLK = ~CLK;

   int n_checks    = 0;
   int n_errors    = 0;
   int cyc         = 0;
   int start_cnt   = 0;
   int start_cyc   = 0;
   int dbl_pulse   = 0;
   bit prev_start  = 1'b0;
   bit model_en    = 1'b0;
   int busy_len    = 5;
   int busy_left   = 0;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n cycles, sampling 1 ns after each rising edge; inputs change
   // at the same point. Tracks start pulses and runs the driver model.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
         cyc++;
         if (DRV_START === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
            if (prev_start) dbl_pulse++;
         end
         prev_start = (DRV_START === 1'b1);
         if (model_en) begin
            if (DRV_START === 1'b1) busy_left = busy_len;
            DRV_BUSY = (busy_left > 0);
            if (busy_left > 0) busy_left--;
         end
      end
   endtask

   // Wait for the next start pulse within a cycle budget.
   task automatic wait_start(input int budget, output bit ok);
      int s0;
      s0 = start_cnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step(1);
         if (start_cnt != s0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // One-cycle WR_DONE pulse with the given count.
   task automatic write_frame(input int count);
      WR_DONE  = 1'b1;
      WR_COUNT = CW'(count);
      step(1);
      WR_DONE  = 1'b0;
   endtask

   // Hard stop if the bench ever stalls.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int t0;
      int t1;
      RESET      = 1'b1;
      WR_DONE    = 1'b0;
      WR_COUNT   = '0;
      REFRESH_EN = 1'b0;
      DRV_BUSY   = 1'b0;

      // Reset state.
      step(3);
      RESET = 1'b0;
      check_eq("rst_rd_bank",   32'(RD_BANK),   32'd1);
      check_eq("rst_wr_bank",   32'(WR_BANK),   32'd0);
      check_eq("rst_wr_ready",  32'(WR_READY),  32'd1);
      check_eq("rst_drv_start", 32'(DRV_START), 32'd0);
      check_eq("rst_drv_count", 32'(DRV_COUNT), 32'd0);

      // Full frame: capture at edge k, swap at k+1, start pulse after k+2.
      model_en  = 1'b1;
      busy_len  = 5;
      start_cnt = 0;
      write_frame(256);
      check_eq("f256_wr_ready_low", 32'(WR_READY), 32'd0);
      check_eq("f256_rd_bank_hold", 32'(RD_BANK),  32'd1);
      step(1);
      check_eq("f256_rd_bank_swap", 32'(RD_BANK),   32'd0);
      check_eq("f256_wr_bank_swap", 32'(WR_BANK),   32'd1);
      check_eq("f256_drv_count",    32'(DRV_COUNT), 32'd256);
      check_eq("f256_wr_ready_hi",  32'(WR_READY),  32'd1);
      check_eq("f256_start_early",  32'(DRV_START), 32'd0);
      step(1);
      check_eq("f256_start_pulse",  32'(DRV_START), 32'd1);
      step(1);
      check_eq("f256_start_drop",   32'(DRV_START), 32'd0);
      step(20);
      check_eq("f256_start_count",  32'(start_cnt), 32'd1);

      // Oversized count saturates at NUM_LEDS.
      start_cnt = 0;
      write_frame(300);
      step(24);
      check_eq("f300_drv_count",   32'(DRV_COUNT), 32'd256);
      check_eq("f300_rd_bank",     32'(RD_BANK),   32'd1);
      check_eq("f300_start_count", 32'(start_cnt), 32'd1);

      // Empty frame: bank handed over, no start pulse.
      start_cnt = 0;
      write_frame(0);
      step(1);
      check_eq("f0_rd_bank",     32'(RD_BANK),   32'd0);
      check_eq("f0_drv_count",   32'(DRV_COUNT), 32'd0);
      check_eq("f0_wr_ready",    32'(WR_READY),  32'd1);
      step(20);
      check_eq("f0_start_count", 32'(start_cnt), 32'd0);

      // Busy driver blocks the swap; a second WR_DONE is an overrun.
      model_en  = 1'b0;
      busy_left = 0;
      DRV_BUSY  = 1'b1;
      start_cnt = 0;
      write_frame(10);
      check_eq("ovr_wr_ready_low", 32'(WR_READY), 32'd0);
      write_frame(20);
      step(1000);
      check_eq("busy_rd_bank_hold", 32'(RD_BANK),   32'd0);
      check_eq("busy_wr_ready",     32'(WR_READY),  32'd0);
      check_eq("busy_no_start",     32'(start_cnt), 32'd0);
      DRV_BUSY = 1'b0;
      model_en = 1'b1;
      step(1);
      check_eq("busy_rd_bank_swap", 32'(RD_BANK),   32'd1);
      check_eq("busy_drv_count",    32'(DRV_COUNT), 32'd10);
      step(1);
      check_eq("busy_start_pulse",  32'(DRV_START), 32'd1);
`ifdef NEOPIX_FRAME_STATS_EN
      check_eq("stats_dropped", 32'(FRAMES_DROPPED), 32'd1);
      step(1);
      check_eq("stats_shown",   32'(FRAMES_SHOWN),   32'd3);
`endif
      step(20);

      // Periodic refresh. The timer is zero during the pulse cycle, reaches
      // 99 after 99 more edges, then IDLE takes one edge to enter START and
      // START one more to raise the pulse: pulses are 101 cycles apart.
      REFRESH_EN = 1'b1;
      wait_start(300, ok);
      check_eq("ref_first_start", 32'(ok), 32'd1);
      t0 = start_cyc;
      wait_start(300, ok);
      check_eq("ref_second_start", 32'(ok), 32'd1);
      t1 = start_cyc;
      check_eq("ref_period_1", 32'(t1 - t0), 32'd101);
      wait_start(300, ok);
      check_eq("ref_third_start", 32'(ok), 32'd1);
      check_eq("ref_period_2", 32'(start_cyc - t1), 32'd101);
      check_eq("ref_rd_bank",   32'(RD_BANK),   32'd1);
      check_eq("ref_drv_count", 32'(DRV_COUNT), 32'd10);

      // Reset in the middle of a send: everything clears, no further starts.
      busy_len = 20;
      wait_start(300, ok);
      check_eq("rst_mid_start_seen", 32'(ok), 32'd1);
      step(3);
      RESET     = 1'b1;
      model_en  = 1'b0;
      busy_left = 0;
      step(1);
      check_eq("rst_mid_drv_start", 32'(DRV_START), 32'd0);
      check_eq("rst_mid_drv_count", 32'(DRV_COUNT), 32'd0);
      check_eq("rst_mid_wr_ready",  32'(WR_READY),  32'd1);
      check_eq("rst_mid_rd_bank",   32'(RD_BANK),   32'd1);
      RESET     = 1'b0;
      DRV_BUSY  = 1'b0;
      start_cnt = 0;
      step(8);
      check_eq("rst_mid_no_start_8", 32'(start_cnt), 32'd0);
`ifdef NEOPIX_FRAME_STATS_EN
      check_eq("rst_mid_stats_shown", 32'(FRAMES_SHOWN), 32'd0);
`endif
      step(300);
      check_eq("rst_mid_no_refresh", 32'(start_cnt), 32'd0);

      check_eq("single_cycle_pulses", 32'(dbl_pulse), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
